mu0_run_ctrl: RTL

Synthesisable run/monitor controller for an MU0 core and its memory. It replaces the fixed reset-then-clock-until-Halted sequencing with parametrised reset length, a clock-enable gate, a cycle watchdog, an address breakpoint with single-step, and saturating cycle/read/write counters. It sits beside mu0 and mu0_memory, driving the core's reset and clock enable and snooping the core's bus.

---
 rtl/mu0_pkg.sv | 16 +
 rtl/mu0_sat_counter.sv | 33 +++
 rtl/mu0_run_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 run/monitor controller: FSM state encoding and default widths.
package mu0_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RESET    = 3'd1,
        RUN      = 3'd2,
        PAUSED   = 3'd3,
        STEP     = 3'd4,
        DONE     = 3'd5,
        TIMEDOUT = 3'd6
    } state_t;

    localparam int unsigned DEFAULT_CNT_W = 32;

endpackage

// File: rtl/mu0_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module mu0_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mu0_run_ctrl.sv
// Run/monitor controller for MU0: reset sequencing, clock-enable gating, watchdog,
// address breakpoint with single-step, and saturating cycle/read/write counters.
module mu0_run_ctrl
    import mu0_pkg::*;
#(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 100000
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Step,
    input  logic              Cont,
    input  logic              Bp_en,
    input  logic [ADDR_W-1:0] Bp_addr,
    input  logic              Halted,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Address,
    output logic              Cpu_reset,
    output logic              Cpu_en,
    output logic [2:0]        State,
    output logic              Done,
    output logic              Timed_out,
    output logic [CNT_W-1:0]  Cycle_count,
    output logic [CNT_W-1:0]  Rd_count,
    output logic [CNT_W-1:0]  Wr_count
);

    localparam logic [CNT_W:0] TIMEOUT_W   = (CNT_W + 1)'(TIMEOUT);
    localparam logic [31:0]    RST_LAST    = 32'(RESET_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] rst_cnt_q, rst_cnt_d;
    logic        skip_bp_q, skip_bp_d;
    logic        bp_hit, wd_hit, clr;

    assign bp_hit = (state_q == RUN) && Bp_en && Rd && (Address == Bp_addr) && !skip_bp_q;

    assign Cpu_en = ((state_q == RUN) || (state_q == STEP)) && !Halted && !bp_hit;

    // Fires on the enabled cycle whose count would reach TIMEOUT; that count is still taken.
    assign wd_hit = (TIMEOUT != 0) && Cpu_en && (({1'b0, Cycle_count} + 1'b1) == TIMEOUT_W);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        skip_bp_d = skip_bp_q;
        clr       = 1'b0;
        unique case (state_q)
            IDLE, DONE, TIMEDOUT: begin
                if (Start) begin
                    state_d   = RESET;
                    rst_cnt_d = '0;
                    skip_bp_d = 1'b0;
                    clr       = 1'b1;
                end
            end
            RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (Halted) begin
                    state_d = DONE;
                end else if (bp_hit) begin
                    state_d = PAUSED;
                end else if (wd_hit) begin
                    state_d = TIMEDOUT;
                end
            end
            PAUSED: begin
                if (Step) begin
                    state_d   = STEP;
                    skip_bp_d = 1'b1;
                end else if (Cont) begin
                    state_d   = RUN;
                    skip_bp_d = 1'b1;
                end
            end
            STEP: begin
                if (Halted) begin
                    state_d = DONE;
                end else if (wd_hit) begin
                    state_d = TIMEDOUT;
                end else begin
                    state_d = PAUSED;
                end
            end
            default: state_d = IDLE;
        endcase
        // Cpu_en is never high in PAUSED, so this cannot undo the set above.
        if (Cpu_en) begin
            skip_bp_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
            skip_bp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            skip_bp_q <= skip_bp_d;
        end
    end

    assign Cpu_reset = (state_q == IDLE) || (state_q == RESET);
    assign State     = state_q;
    assign Done      = (state_q == DONE);
    assign Timed_out = (state_q == TIMEDOUT);

    mu0_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .clr    (clr),
        .inc    (Cpu_en),
        .count  (Cycle_count)
    );

    mu0_sat_counter #(.WIDTH(CNT_W)) u_rd_cnt (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .clr    (clr),
        .inc    (Cpu_en && Rd),
        .count  (Rd_count)
    );

    mu0_sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .clr    (clr),
        .inc    (Cpu_en && Wr),
        .count  (Wr_count)
    );

endmodule
